io_peripherals: RTL
===================

Name: io_peripherals

Overview:
Memory-mapped I/O register block directly downstream of the unified memory decoder. It is selected for byte addresses 0x800 and above and receives a 5-bit offset from that base.
- Provides read-only views of switches, buttons and input pins.
- Provides writable LED, output-pin and 4-digit seven-segment registers.
- Buttons are synchronised and debounced; the display is time-multiplexed.
- RD is combinational so the memory decoder can mux it in the same cycle.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a button's debounced state changes
SCAN_CYCLES, 100000, clock cycles each display digit is driven before advancing
NUM_BTN, 5, number of push buttons

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
A  input  5  byte offset from peripheral base; A[4:2] selects a register, A[1:0] ignored
WD  input  32  write data
WE  input  1  write enable, already qualified by peripheral select
RD  output  32  read data, combinational from A
sw  input  16  slide switches (asynchronous)
btn  input  NUM_BTN  push buttons (asynchronous, bouncy)
ipin  input  4  general input pins (asynchronous)
led  output  16  LED drive
opin  output  4  general output pins
hex  output  7  segments {g,f,e,d,c,b,a}, active-low
hex_dot  output  1  decimal point, active-low
hex_sel  output  4  digit anodes, active-low, one-hot-low

Behaviour:
Clocking and reset:
- One clock. Reset is asynchronous and active-low.
- Reset clears all registers, synchronisers, debounce counters and scan state.
Register map (A[4:2]):
- 0 SW: RO = {16'b0, sw_sync}.
- 1 BTN: RO = {27'b0, btn_db}.
- 2 IPIN: RO = {28'b0, ipin_sync}.
- 3 LED: RW [15:0].
- 4 OPIN: RW [3:0].
- 5 HEX_VAL: RW [15:0]; nibble i is shown on digit i, digit 0 rightmost.
- 6 HEX_CFG: RW; [3:0] dot per digit, [7:4] digit enable mask.
- 7 BTN_EVT: see Optional Feature.
Read/write rules:
- Unimplemented bits read 0.
- Writes take effect on the rising clk edge when WE=1. Read-only registers ignore writes.
- RD reflects register state with zero latency. A read in the same cycle as a write returns the old value.
Synchronisers:
- sw and ipin each pass through 2 flops, so latency is 2 cycles.
Debounce (per button):
- 2-flop synchroniser, then a counter.
- Counter resets whenever the synced input equals btn_db.
- When the counter reaches DEBOUNCE_CYCLES-1 while the input still differs, btn_db toggles and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES never changes btn_db.
Display scan:
- Prescaler counts 0..SCAN_CYCLES-1. At wrap, the digit index advances 0→1→2→3→0.
- hex_sel drives the current digit low only if its enable bit is set; otherwise hex_sel=4'hF.
- hex = active-low hex-font encoding of the selected nibble (0-F).
- hex_dot = ~dot[idx].
- A write to HEX_VAL or HEX_CFG is visible no later than the next clk.
Reset output values:
- led=0, opin=0, hex_sel=4'hF, hex=7'h7F, hex_dot=1, digit index=0, btn_db=0.
Reset mid-operation:
- Aborts debounce and scan immediately.
- No pending write survives.

Optional Feature:
Macro IO_PERIPHERALS_BTN_EVT_EN.
- Defined: register 7 is a sticky rising-edge capture of btn_db, [NUM_BTN-1:0].
  - A bit sets on the cycle btn_db rises.
  - Writing 1 to a bit clears it.
  - If set and clear happen in the same cycle, set wins.
  - Reset value 0.
- Undefined: register 7 reads 0, writes are ignored, and no capture logic exists.

Decomposition:
- Package io_periph_pkg holds:
  - register index constants (REG_SW .. REG_BTN_EVT);
  - active-low 7-segment font function (nibble → 7 bits);
  - digit count constant 4.
- Sub-module btn_debounce (single bit: synchroniser plus counter, parameter DEBOUNCE_CYCLES) is instantiated NUM_BTN times.

Test Plan:
Bench uses DEBOUNCE_CYCLES=8, SCAN_CYCLES=4.
1. Reset: hold rst_n=0 mid-scan → led=0, opin=0, hex_sel=F, hex=7F, hex_dot=1; after release, A=0x0C reads 0.
2. Write A=0x0C, WD=0x0000A5F0 → led=A5F0 next cycle; read of A=0x0C returns 0x0000A5F0; write to A=0x00 leaves SW read equal to sw.
3. Debounce: btn[2] pulses high for 5 cycles → BTN reads 0. Then hold high for 12 cycles → BTN=0x04 no earlier than 2+8 cycles after the edge.
4. Scan: HEX_VAL=0x12AF, HEX_CFG=0xF1 → hex_sel cycles E,D,B,7 every 4 clks. hex is 0x0E (F) with hex_dot=0 on digit 0, then 0x08 (A), 0x24 (2), 0x79 (1). With HEX_CFG=0x51, digits 1 and 3 show hex_sel=F.
5. Sync latency: sw changes 0→0xBEEF → SW reads 0xBEEF exactly 2 cycles later; ipin=0x9 likewise.
6. With IO_PERIPHERALS_BTN_EVT_EN: btn[0] debounced rise → EVT=0x01. Write 0x01 in the same cycle as a new btn[0] rise → stays 0x01. Write 0x01 alone → EVT=0.

Source files
------------

// File: rtl/io_periph_pkg.sv
// Shared definitions for the memory-mapped I/O block: register indices,
// digit count and the active-low seven-segment font.
package io_periph_pkg;

    localparam logic [2:0] REG_SW      = 3'd0;
    localparam logic [2:0] REG_BTN     = 3'd1;
    localparam logic [2:0] REG_IPIN    = 3'd2;
    localparam logic [2:0] REG_LED     = 3'd3;
    localparam logic [2:0] REG_OPIN    = 3'd4;
    localparam logic [2:0] REG_HEX_VAL = 3'd5;
    localparam logic [2:0] REG_HEX_CFG = 3'd6;
    localparam logic [2:0] REG_BTN_EVT = 3'd7;

    localparam int NUM_DIGITS = 4;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] seg7_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_peripherals_btn_debounce.sv
// Single-bit button conditioner: two-flop synchroniser followed by a
// stability counter that toggles the debounced state.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic db_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q, db_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            // Any cycle where the input agrees with the output restarts the count.
            if (sync2_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                db_q  <= ~db_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/io_peripherals.sv
// Memory-mapped switches/buttons/pins/LEDs/seven-segment block.
// Define IO_PERIPHERALS_BTN_EVT_EN to add the sticky button-event register.
module io_peripherals
    import io_periph_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_CYCLES     = 100000,
    parameter int NUM_BTN         = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         A,
    input  logic [31:0]        WD,
    input  logic               WE,
    output logic [31:0]        RD,
    input  logic [15:0]        sw,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [3:0]         ipin,
    output logic [15:0]        led,
    output logic [3:0]         opin,
    output logic [6:0]         hex,
    output logic               hex_dot,
    output logic [3:0]         hex_sel
);

    localparam int PS_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(SCAN_CYCLES - 1);

    logic [2:0]         reg_idx;
    logic [15:0]        sw_s1_q, sw_s2_q;
    logic [3:0]         ip_s1_q, ip_s2_q;
    logic [NUM_BTN-1:0] btn_db;
    logic [15:0]        led_q, led_d, hexval_q, hexval_d;
    logic [3:0]         opin_q, opin_d;
    logic [7:0]         hexcfg_q, hexcfg_d;
    logic [PS_W-1:0]    presc_q, presc_d;
    logic [1:0]         idx_q, idx_d;
    logic [6:0]         hex_q, hex_d;
    logic [3:0]         sel_q, sel_d;
    logic               dot_q, dot_d;
    logic               unused_bits;

    assign reg_idx     = A[4:2];
    assign unused_bits = ^{A[1:0], WD[31:16]};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .btn_i(btn[g]),
            .db_o (btn_db[g])
        );
    end

    // Display outputs are computed from next-state values so a register
    // write shows up on the same edge that commits it.
    always_comb begin
        led_d    = led_q;
        opin_d   = opin_q;
        hexval_d = hexval_q;
        hexcfg_d = hexcfg_q;
        if (WE) begin
            case (reg_idx)
                REG_LED:     led_d    = WD[15:0];
                REG_OPIN:    opin_d   = WD[3:0];
                REG_HEX_VAL: hexval_d = WD[15:0];
                REG_HEX_CFG: hexcfg_d = WD[7:0];
                default:     ;
            endcase
        end
        presc_d = (presc_q == PS_MAX) ? '0 : presc_q + PS_W'(1);
        idx_d   = (presc_q == PS_MAX) ? idx_q + 2'd1 : idx_q;
        hex_d   = seg7_font(hexval_d[{idx_d, 2'b00} +: 4]);
        sel_d   = hexcfg_d[{1'b1, idx_d}] ? ~(4'b0001 << idx_d) : 4'hF;
        dot_d   = ~hexcfg_d[{1'b0, idx_d}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            ip_s1_q  <= '0;
            ip_s2_q  <= '0;
            led_q    <= '0;
            opin_q   <= '0;
            hexval_q <= '0;
            hexcfg_q <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            hex_q    <= 7'h7F;
            sel_q    <= 4'hF;
            dot_q    <= 1'b1;
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            ip_s1_q  <= ipin;
            ip_s2_q  <= ip_s1_q;
            led_q    <= led_d;
            opin_q   <= opin_d;
            hexval_q <= hexval_d;
            hexcfg_q <= hexcfg_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            hex_q    <= hex_d;
            sel_q    <= sel_d;
            dot_q    <= dot_d;
        end
    end

`ifdef IO_PERIPHERALS_BTN_EVT_EN
    logic [NUM_BTN-1:0] db_prev_q, evt_q, evt_d, evt_clr;

    // A rise in the same cycle as a write-one-to-clear keeps the bit set.
    always_comb begin
        evt_clr = (WE && reg_idx == REG_BTN_EVT) ? WD[NUM_BTN-1:0] : '0;
        evt_d   = (evt_q & ~evt_clr) | (btn_db & ~db_prev_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev_q <= '0;
            evt_q     <= '0;
        end else begin
            db_prev_q <= btn_db;
            evt_q     <= evt_d;
        end
    end
`endif

    always_comb begin
        RD = '0;
        case (reg_idx)
            REG_SW:      RD[15:0]        = sw_s2_q;
            REG_BTN:     RD[NUM_BTN-1:0] = btn_db;
            REG_IPIN:    RD[3:0]         = ip_s2_q;
            REG_LED:     RD[15:0]        = led_q;
            REG_OPIN:    RD[3:0]         = opin_q;
            REG_HEX_VAL: RD[15:0]        = hexval_q;
            REG_HEX_CFG: RD[7:0]         = hexcfg_q;
`ifdef IO_PERIPHERALS_BTN_EVT_EN
            REG_BTN_EVT: RD[NUM_BTN-1:0] = evt_q;
`endif
            default:     RD = '0;
        endcase
    end

    assign led     = led_q;
    assign opin    = opin_q;
    assign hex     = hex_q;
    assign hex_sel = sel_q;
    assign hex_dot = dot_q;

endmodule
